pe_seq_ctrl: RTL and testbench
==============================

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 Parameter N_PE, default 8, number of chained MAC PEs sequenced (>=2).
REQ-002 Parameter PIPE_LAT, default N_PE+1, cycles from accepted activation beat to its result at chain_out.
REQ-003 Parameter LEN_W, default 16, width of cfg_len and beat counters.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin a job; ignored while busy=1.
REQ-007 cfg_len  in  LEN_W  activation beats per job, sampled at accepted start.
REQ-008 busy  out  1  high from the cycle after accepted start until done.
REQ-009 done  out  1  one-cycle pulse, end of job.
REQ-010 w_req / w_vld / w_data  out 1 / in 1 / in 8  weight handshake; byte transfers when w_req&w_vld.
REQ-011 d_req / d_vld / d_data  out 1 / in 1 / in 8  activation handshake; beat transfers when d_req&d_vld.
REQ-012 pe_w_en  out  N_PE  one-hot weight-load strobe, bit i loads PE i.
REQ-013 pe_w_in, pe_d_in  out  8  weight byte and activation byte to the PE chain.
REQ-014 pe_en_pu, pe_en_in, pe_zero_en  out  1  PE enable update, enable value, enable clear.
REQ-015 chain_out  in  32 signed  partial sum from last PE.
REQ-016 res_data  out  32 signed; res_vld  out  1  result beat and its qualifier.

Function
REQ-017 FSM states IDLE, CLEAR, WLOAD, COMPUTE, DRAIN, DONE; register next-state, outputs decoded from state plus handshake inputs.
REQ-018 IDLE: all outputs 0; start=1 latches cfg_len, goes to CLEAR.
REQ-019 CLEAR: exactly one cycle, pe_zero_en=1, pe_en_pu=0; next WLOAD with w_idx=0.
REQ-020 WLOAD: w_req=1; on transfer pe_w_en=(1<<w_idx) same cycle, pe_w_in=w_data, w_idx increments; w_vld=0 holds w_idx, pe_w_en=0.
REQ-021 WLOAD exits to COMPUTE in the cycle after the N_PE-th transfer; w_idx wraps to 0.
REQ-022 COMPUTE: d_req=1, pe_en_pu=1 every cycle, pe_en_in=d_vld, pe_d_in=d_vld?d_data:0; beat counter increments per transfer.
REQ-023 COMPUTE exits to DRAIN in the cycle after the cfg_len-th transfer; d_req deasserts in that next cycle.
REQ-024 cfg_len=0: WLOAD (or CLEAR under REQ-032) goes directly to DRAIN; no d_req asserted; no res_vld produced.
REQ-025 Valid shift register of PIPE_LAT bits shifts every cycle in COMPUTE/DRAIN, input = accepted beat; res_vld = tail bit, res_data = chain_out (pass-through).
REQ-026 Each accepted beat produces exactly one res_vld exactly PIPE_LAT cycles later; bubbles produce none.
REQ-027 DRAIN: pe_en_pu=1, pe_en_in=0, pe_d_in=0; exits to DONE when shift register is all zero.
REQ-028 DONE: done=1, busy=0 for one cycle; next IDLE; start in DONE is ignored.
REQ-029 No backpressure on res_*; downstream always accepts.

Reset
REQ-030 rst low at any time, including mid-job: state=IDLE, counters, w_idx and shift register cleared, all outputs 0 asynchronously; in-flight beats are discarded without res_vld.

Configuration
REQ-031 Macro PE_SEQ_CTRL_WREUSE_EN compiles in input port reuse_w (in, 1), sampled with start.
REQ-032 With macro and reuse_w=1: CLEAR goes to COMPUTE, skipping WLOAD; PE weights retained from prior job; reuse_w=0 behaves as without macro.
REQ-033 Without macro: no reuse_w port; every job executes WLOAD.

Verification
REQ-034 N_PE=4, start, cfg_len=3, w_vld constant 1, weights 1,2,3,4 -> pe_w_en 0001,0010,0100,1000 on consecutive cycles with matching pe_w_in.
REQ-035 cfg_len=3, d_vld pattern 1,0,1,1 -> 3 res_vld pulses at PIPE_LAT=5 cycles after each accepted beat, one gap; done once.
REQ-036 cfg_len=0 -> CLEAR, WLOAD, DRAIN, DONE; d_req never 1; res_vld never 1; done pulse.
REQ-037 rst low during COMPUTE after 2 beats -> busy=0, res_vld=0 immediately; next job's first res_vld only from new beats.
REQ-038 start pulsed during WLOAD -> ignored, cfg_len unchanged, single done.
REQ-039 Macro defined, second job reuse_w=1 -> w_req never asserted; first d_req 2 cycles after start.

Source files
------------

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequences a chain of N_PE MAC PEs through clear, weight load, compute and drain.
// Optional macro PE_SEQ_CTRL_WREUSE_EN adds reuse_w, letting a job keep the previous job's weights.
module pe_seq_ctrl #(
   parameter int N_PE     = 8,
   parameter int PIPE_LAT = N_PE + 1,
   parameter int LEN_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [LEN_W-1:0]    cfg_len,
`ifdef PE_SEQ_CTRL_WREUSE_EN
   input  logic                reuse_w,
`endif
   output logic                busy,
   output logic                done,
   output logic                w_req,
   input  logic                w_vld,
   input  logic [7:0]          w_data,
   output logic                d_req,
   input  logic                d_vld,
   input  logic [7:0]          d_data,
   output logic [N_PE-1:0]     pe_w_en,
   output logic [7:0]          pe_w_in,
   output logic [7:0]          pe_d_in,
   output logic                pe_en_pu,
   output logic                pe_en_in,
   output logic                pe_zero_en,
   input  logic signed [31:0]  chain_out,
   output logic signed [31:0]  res_data,
   output logic                res_vld,
   output logic [2:0]          state_dbg
);

   // Handshakes: a weight byte moves in any cycle with w_req && w_vld, an activation
   // beat in any cycle with d_req && d_vld; req never waits on vld. res_* has no ready.

   localparam int WIDX_W = (N_PE > 1) ? $clog2(N_PE) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLEAR   = 3'd1;
   localparam logic [2:0] S_WLOAD   = 3'd2;
   localparam logic [2:0] S_COMPUTE = 3'd3;
   localparam logic [2:0] S_DRAIN   = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [N_PE-1:0]   PE0_SEL  = {{(N_PE-1){1'b0}}, 1'b1};
   localparam logic [WIDX_W-1:0] WIDX_END = WIDX_W'(N_PE - 1);

   logic [2:0]          state;
   logic [2:0]          state_nxt;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    beat_cnt;
   logic [WIDX_W-1:0]   w_idx;
   logic [PIPE_LAT-1:0] vsr;
   logic                reuse_q;

   logic w_xfer;
   logic d_xfer;
   logic w_last;
   logic d_last;
   logic len_zero;
   logic in_pipe;

   assign w_xfer   = (state == S_WLOAD) && w_vld;
   assign d_xfer   = (state == S_COMPUTE) && d_vld;
   assign w_last   = (w_idx == WIDX_END);
   assign d_last   = ((beat_cnt + LEN_W'(1)) == len_q);
   assign len_zero = (len_q == '0);
   assign in_pipe  = (state == S_COMPUTE) || (state == S_DRAIN);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            if (reuse_q) state_nxt = len_zero ? S_DRAIN : S_COMPUTE;
            else         state_nxt = S_WLOAD;
         end
         S_WLOAD: begin
            if (w_xfer && w_last) state_nxt = len_zero ? S_DRAIN : S_COMPUTE;
         end
         S_COMPUTE: begin
            if (d_xfer && d_last) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            // Leave only once every accepted beat has surfaced at res_vld.
            if (vsr == '0) state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         len_q    <= '0;
         beat_cnt <= '0;
         w_idx    <= '0;
         vsr      <= '0;
      end else begin
         state <= state_nxt;
         if ((state == S_IDLE) && start) len_q <= cfg_len;

         if (state == S_CLEAR)  w_idx <= '0;
         else if (w_xfer)       w_idx <= w_last ? '0 : w_idx + WIDX_W'(1);

         if (state == S_CLEAR)  beat_cnt <= '0;
         else if (d_xfer)       beat_cnt <= beat_cnt + LEN_W'(1);

         // One bit per accepted beat travels PIPE_LAT stages alongside the PE chain.
         if (in_pipe) vsr <= PIPE_LAT'({vsr, d_xfer});
         else         vsr <= '0;
      end
   end

`ifdef PE_SEQ_CTRL_WREUSE_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reuse_q <= 1'b0;
      end else if ((state == S_IDLE) && start) begin
         reuse_q <= reuse_w;
      end
   end
`else
   assign reuse_q = 1'b0;
`endif

   always_comb begin
      busy       = (state == S_CLEAR) || (state == S_WLOAD) || in_pipe;
      done       = (state == S_DONE);
      w_req      = (state == S_WLOAD);
      d_req      = (state == S_COMPUTE);
      pe_w_en    = w_xfer ? (PE0_SEL << w_idx) : '0;
      pe_w_in    = w_xfer ? w_data : 8'd0;
      pe_d_in    = d_xfer ? d_data : 8'd0;
      pe_en_pu   = in_pipe;
      pe_en_in   = d_xfer;
      pe_zero_en = (state == S_CLEAR);
      res_vld    = vsr[PIPE_LAT-1];
      res_data   = in_pipe ? chain_out : 32'sd0;
      state_dbg  = state;
   end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: directed jobs played from per-cycle stimulus tables; a cycle-timeline model
// derived from the job rules predicts every output and is compared each negedge.
module tb_pe_seq_ctrl;

   localparam int N_PE     = 4;
   localparam int PIPE_LAT = N_PE + 1;
   localparam int LEN_W    = 16;
   localparam int MAXC     = 400;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [LEN_W-1:0]    cfg_len;
`ifdef PE_SEQ_CTRL_WREUSE_EN
   logic                reuse_w;
`endif
   logic                busy, done, w_req, w_vld, d_req, d_vld;
   logic [7:0]          w_data, d_data, pe_w_in, pe_d_in;
   logic [N_PE-1:0]     pe_w_en;
   logic                pe_en_pu, pe_en_in, pe_zero_en, res_vld;
   logic signed [31:0]  chain_out, res_data;
   logic [2:0]          state_dbg;

   pe_seq_ctrl #(.N_PE(N_PE), .PIPE_LAT(PIPE_LAT), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
`ifdef PE_SEQ_CTRL_WREUSE_EN
      .reuse_w(reuse_w),
`endif
      .busy(busy), .done(done),
      .w_req(w_req), .w_vld(w_vld), .w_data(w_data),
      .d_req(d_req), .d_vld(d_vld), .d_data(d_data),
      .pe_w_en(pe_w_en), .pe_w_in(pe_w_in), .pe_d_in(pe_d_in),
      .pe_en_pu(pe_en_pu), .pe_en_in(pe_en_in), .pe_zero_en(pe_zero_en),
      .chain_out(chain_out), .res_data(res_data), .res_vld(res_vld),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // stimulus tables, one entry per cycle
   logic        drv_rst[MAXC], drv_start[MAXC], drv_reuse[MAXC], drv_wv[MAXC], drv_dv[MAXC];
   logic [15:0] drv_len[MAXC];
   logic [7:0]  drv_wd[MAXC], drv_dd[MAXC];
   logic [31:0] drv_co[MAXC];

   // model timeline, one entry per cycle
   logic            e_busy[MAXC], e_done[MAXC], e_wreq[MAXC], e_dreq[MAXC];
   logic            e_zero[MAXC], e_pu[MAXC], e_enin[MAXC], e_resv[MAXC];
   logic [N_PE-1:0] e_wen[MAXC];
   logic [7:0]      e_win[MAXC], e_din[MAXC];

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int cyc    = -1;
   int done_cnt = 0;
   int res_seen_q[$];
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Builds the expected timeline of one job started (start high) in cycle s.
   // Pattern bits are consumed LSB first; past bit 15 the source is always valid.
   task automatic plan_job(input int s, input int len, input logic [15:0] wv_pat,
                           input logic [15:0] dv_pat, input logic reuse, input logic seq_w,
                           output int done_c);
      int c, k, idx, acc, last_res, drain_end;
      logic v;
      logic [N_PE-1:0] one;
      one = 1;
      drv_start[s] = 1'b1;
      drv_len[s]   = 16'(len);
      drv_reuse[s] = reuse;
      c = s + 1;
      e_zero[c] = 1'b1; e_busy[c] = 1'b1;
      c++;
      if (!reuse) begin
         k = 0; idx = 0;
         while (idx < N_PE) begin
            v = (k < 16) ? wv_pat[k] : 1'b1;
            drv_wv[c] = v; e_wreq[c] = 1'b1; e_busy[c] = 1'b1;
            if (v) begin
               if (seq_w) drv_wd[c] = 8'(idx + 1);
               e_wen[c] = one << idx;
               e_win[c] = drv_wd[c];
               idx++;
            end
            k++; c++;
         end
      end
      last_res = -1; acc = 0; k = 0;
      while (acc < len) begin
         v = (k < 16) ? dv_pat[k] : 1'b1;
         drv_dv[c] = v; e_dreq[c] = 1'b1; e_pu[c] = 1'b1; e_busy[c] = 1'b1;
         if (v) begin
            e_enin[c] = 1'b1;
            e_din[c]  = drv_dd[c];
            e_resv[c + PIPE_LAT] = 1'b1;
            last_res = c + PIPE_LAT;
            acc++;
         end
         k++; c++;
      end
      // draining lasts until the cycle after the last result has left
      drain_end = (last_res < 0) ? c : last_res + 1;
      while (c <= drain_end) begin
         e_pu[c] = 1'b1; e_busy[c] = 1'b1;
         c++;
      end
      e_done[c] = 1'b1;
      done_c = c;
   endtask

   task automatic clear_exp(input int lo, input int hi);
      for (int c = lo; c <= hi && c < MAXC; c++) begin
         e_busy[c] = 0; e_done[c] = 0; e_wreq[c] = 0; e_dreq[c] = 0;
         e_zero[c] = 0; e_pu[c] = 0; e_enin[c] = 0; e_resv[c] = 0;
         e_wen[c] = '0; e_win[c] = '0; e_din[c] = '0;
      end
   endtask

   // driver: apply cycle cyc's inputs just after the rising edge
   always @(posedge clk) begin
      cyc++;
      #1;
      if (cyc < MAXC) begin
         rst = drv_rst[cyc]; start = drv_start[cyc]; cfg_len = drv_len[cyc];
`ifdef PE_SEQ_CTRL_WREUSE_EN
         reuse_w = drv_reuse[cyc];
`endif
         w_vld = drv_wv[cyc]; w_data = drv_wd[cyc];
         d_vld = drv_dv[cyc]; d_data = drv_dd[cyc];
         chain_out = drv_co[cyc];
      end
   end

   // compare process
   always @(negedge clk) begin
      if (cyc >= 0 && cyc < MAXC) begin
         chk("busy",       cyc, busy,       e_busy[cyc]);
         chk("done",       cyc, done,       e_done[cyc]);
         chk("w_req",      cyc, w_req,      e_wreq[cyc]);
         chk("pe_w_en",    cyc, pe_w_en,    e_wen[cyc]);
         chk("d_req",      cyc, d_req,      e_dreq[cyc]);
         chk("pe_zero_en", cyc, pe_zero_en, e_zero[cyc]);
         chk("pe_en_pu",   cyc, pe_en_pu,   e_pu[cyc]);
         chk("pe_en_in",   cyc, pe_en_in,   e_enin[cyc]);
         chk("pe_d_in",    cyc, pe_d_in,    e_din[cyc]);
         chk("res_vld",    cyc, res_vld,    e_resv[cyc]);
         if (e_wen[cyc] != '0) chk("pe_w_in", cyc, pe_w_in, e_win[cyc]);
         if (e_resv[cyc])      chk("res_data", cyc, res_data, drv_co[cyc]);
         if (!rst)             chk("rst_res_data", cyc, res_data, 32'd0);
         if (res_vld) res_seen_q.push_back(cyc);
         if (done) done_cnt++;
      end
   end

   initial begin
      int d1, d2, d3, d4, d5, s, r, end_c, exp_done;
      logic [3:0] j1_res;
      rst = 1'b0; start = 1'b0; cfg_len = '0; w_vld = 1'b0; w_data = '0;
      d_vld = 1'b0; d_data = '0; chain_out = '0;
`ifdef PE_SEQ_CTRL_WREUSE_EN
      reuse_w = 1'b0;
`endif
      for (int c = 0; c < MAXC; c++) begin
         drv_rst[c] = (c >= 3); drv_start[c] = 1'b0; drv_reuse[c] = 1'b0;
         drv_len[c] = 16'($urandom_range(1, 20));
         drv_wv[c] = 1'b1; drv_wd[c] = 8'($urandom_range(0, 255));
         drv_dv[c] = 1'($urandom_range(0, 1)); drv_dd[c] = 8'($urandom_range(0, 255));
         drv_co[c] = $urandom;
      end
      clear_exp(0, MAXC - 1);

      // J1: four weights 1..4 back to back, three beats with one bubble
      plan_job(5, 3, 16'hFFFF, 16'h000D, 1'b0, 1'b1, d1);
      // J2: zero-length job
      plan_job(d1 + 3, 0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, d2);
      // J3: weight stalls, beat bubbles, stray starts in WLOAD and DONE
      s = d2 + 3;
      plan_job(s, 4, 16'h002D, 16'h00B7, 1'b0, 1'b0, d3);
      drv_start[s + 3] = 1'b1; drv_len[s + 3] = 16'd9;
      drv_start[d3] = 1'b1; drv_len[d3] = 16'd2;
      // J4: reset lands after two accepted beats; nothing of it may surface
      s = d3 + 3;
      plan_job(s, 5, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, d4);
      r = s + 8;
      clear_exp(r, d4 + PIPE_LAT);
      drv_rst[r] = 1'b0; drv_rst[r + 1] = 1'b0;
      // J5: fresh job after reset
      plan_job(r + 4, 6, 16'hFFFF, 16'h0155, 1'b0, 1'b0, d5);
      end_c = d5 + 8;
`ifdef PE_SEQ_CTRL_WREUSE_EN
      begin
         int d6, d7, s6;
         s6 = d5 + 3;
         plan_job(s6, 2, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, d6);
         chk("pin_reuse_dreq", s6 + 2, e_dreq[s6 + 2], 1'b1);
         chk("pin_reuse_clear", s6 + 1, e_zero[s6 + 1], 1'b1);
         plan_job(d6 + 3, 0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, d7);
         chk("pin_reuse_len0", d7, d7 - (d6 + 3), 3);
         end_c = d7 + 8;
      end
`endif

      // hand-computed pins on the model itself
      chk("pin_j1_done", 0, d1, 21);
      chk("pin_j2_done", 0, d2, 31);
      for (int k = 0; k < N_PE; k++) begin
         chk("pin_j1_wen", 7 + k, e_wen[7 + k], 32'(1 << k));
         chk("pin_j1_win", 7 + k, e_win[7 + k], 32'(k + 1));
      end
      j1_res = {e_resv[19], e_resv[18], e_resv[17], e_resv[16]};
      chk("pin_j1_resv", 0, j1_res, 4'b1101);

      exp_done = 0;
      for (int c = 0; c < MAXC; c++) if (e_done[c]) exp_done++;
      exp_q.push_back(32'd16); exp_q.push_back(32'd18); exp_q.push_back(32'd19);

      repeat (end_c + 2) @(posedge clk);
      #2;
      chk("done_count", end_c, done_cnt, exp_done);
      for (int i = 0; i < 3; i++) begin
         if (res_seen_q.size() > i) chk("j1_res_cycle", i, res_seen_q[i], exp_q[i]);
         else chk("j1_res_count", i, res_seen_q.size(), 3);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
